// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : LEGv8 memory stage. EX/MEM register, data-memory req/ack
//               handshake, branch resolve, registered writeback result.
//               Optional macro MEM_ALIGN_CHECK_EN faults misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int N = 64
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid_E,
    input  logic         i_memRead_E,
    input  logic         i_memWrite_E,
    input  logic         i_branch_E,
    input  logic         i_regWrite_E,
    input  logic         i_memtoReg_E,
    input  logic [N-1:0] i_aluResult_E,
    input  logic [N-1:0] i_writeData_E,
    input  logic [N-1:0] i_PCBranch_E,
    input  logic         i_zero_E,
    input  logic [4:0]   i_rd_E,
    input  logic         i_flush_M,
    output logic         o_stall_M,
    output logic         o_PCSrc_M,
    output logic [N-1:0] o_PCBranch_M,
    output logic         o_dm_req,
    output logic         o_dm_we,
    output logic [N-1:0] o_dm_addr,
    output logic [N-1:0] o_dm_wdata,
    input  logic         i_dm_ack,
    input  logic [N-1:0] i_dm_rdata,
    output logic         o_valid_W,
    output logic         o_regWrite_W,
    output logic [4:0]   o_rd_W,
    output logic [N-1:0] o_result_W,
    output logic         o_misalign_W
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    // EX/MEM pipeline register
    logic           r_valid_M;
    logic           r_memRead_M;
    logic           r_memWrite_M;
    logic           r_branch_M;
    logic           r_regWrite_M;
    logic           r_memtoReg_M;
    logic [N-1:0]   r_aluResult_M;
    logic [N-1:0]   r_writeData_M;
    logic [N-1:0]   r_PCBranch_M;
    logic           r_zero_M;
    logic [4:0]     r_rd_M;
    logic [N-1:0]   r_rdata_M;

    // MEM/WB pipeline register
    logic           r_valid_W;
    logic           r_regWrite_W;
    logic [4:0]     r_rd_W;
    logic [N-1:0]   r_result_W;
    logic           r_misalign_W;

    logic           w_stall;
    logic           w_capture_valid;
    logic           w_capture_mem;
    logic           w_misal_E;
    logic           w_misal_M;

    assign w_stall         = (r_state == S_REQ);
    assign w_capture_valid = i_valid_E & ~i_flush_M;
    assign w_capture_mem   = w_capture_valid & (i_memRead_E | i_memWrite_E);

`ifdef MEM_ALIGN_CHECK_EN
    logic w_mem_M;
    assign w_mem_M   = r_valid_M & (r_memRead_M | r_memWrite_M);
    assign w_misal_E = |i_aluResult_E[2:0];
    assign w_misal_M = w_mem_M & (|r_aluResult_M[2:0]);
`else
    assign w_misal_E = 1'b0;
    assign w_misal_M = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The next state on a non-stalled edge depends on the op being captured
    // at that same edge, so it is decoded from the execute-stage inputs.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_REQ: begin
                if (i_dm_ack) begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                if (w_capture_mem) begin
                    w_state_next = w_misal_E ? S_DONE : S_REQ;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_valid_M     <= 1'b0;
            r_memRead_M   <= 1'b0;
            r_memWrite_M  <= 1'b0;
            r_branch_M    <= 1'b0;
            r_regWrite_M  <= 1'b0;
            r_memtoReg_M  <= 1'b0;
            r_aluResult_M <= '0;
            r_writeData_M <= '0;
            r_PCBranch_M  <= '0;
            r_zero_M      <= 1'b0;
            r_rd_M        <= '0;
        end else if (!w_stall) begin
            r_valid_M     <= w_capture_valid;
            r_memRead_M   <= i_memRead_E;
            r_memWrite_M  <= i_memWrite_E;
            r_branch_M    <= i_branch_E;
            r_regWrite_M  <= i_regWrite_E;
            r_memtoReg_M  <= i_memtoReg_E;
            r_aluResult_M <= i_aluResult_E;
            r_writeData_M <= i_writeData_E;
            r_PCBranch_M  <= i_PCBranch_E;
            r_zero_M      <= i_zero_E;
            r_rd_M        <= i_rd_E;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_rdata_M <= '0;
        end else if (w_stall && i_dm_ack) begin
            r_rdata_M <= i_dm_rdata;
        end
    end

    // A misaligned op still retires (valid) but must never write the file.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_valid_W    <= 1'b0;
            r_regWrite_W <= 1'b0;
            r_rd_W       <= '0;
            r_result_W   <= '0;
            r_misalign_W <= 1'b0;
        end else if (!w_stall) begin
            r_valid_W    <= r_valid_M;
            r_regWrite_W <= r_valid_M & r_regWrite_M & ~w_misal_M;
            r_rd_W       <= r_rd_M;
            r_result_W   <= r_memtoReg_M ? r_rdata_M : r_aluResult_M;
            r_misalign_W <= w_misal_M;
        end else begin
            r_valid_W    <= 1'b0;
            r_regWrite_W <= 1'b0;
            r_misalign_W <= 1'b0;
        end
    end

    assign o_stall_M    = w_stall;
    assign o_dm_req     = w_stall;
    assign o_dm_we      = w_stall & r_memWrite_M;
    assign o_dm_addr    = r_aluResult_M;
    assign o_dm_wdata   = r_writeData_M;
    assign o_PCSrc_M    = r_valid_M & r_branch_M & r_zero_M;
    assign o_PCBranch_M = r_PCBranch_M;
    assign o_valid_W    = r_valid_W;
    assign o_regWrite_W = r_regWrite_W;
    assign o_rd_W       = r_rd_W;
    assign o_result_W   = r_result_W;
    assign o_misalign_W = r_misalign_W;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard bench for mem_stage with directed LEGv8 ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_E, memRead_E, memWrite_E, branch_E, regWrite_E, memtoReg_E;
    logic [63:0] aluResult_E, writeData_E, PCBranch_E;
    logic        zero_E;
    logic [4:0]  rd_E;
    logic        flush_M;
    logic        stall_M, PCSrc_M;
    logic [63:0] PCBranch_M;
    logic        dm_req, dm_we;
    logic [63:0] dm_addr, dm_wdata;
    logic        dm_ack;
    logic [63:0] dm_rdata;
    logic        valid_W, regWrite_W;
    logic [4:0]  rd_W;
    logic [63:0] result_W;
    logic        misalign_W;

    always #5 clk = ~clk;

    mem_stage #(.N(64)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_valid_E(valid_E), .i_memRead_E(memRead_E), .i_memWrite_E(memWrite_E),
        .i_branch_E(branch_E), .i_regWrite_E(regWrite_E), .i_memtoReg_E(memtoReg_E),
        .i_aluResult_E(aluResult_E), .i_writeData_E(writeData_E), .i_PCBranch_E(PCBranch_E),
        .i_zero_E(zero_E), .i_rd_E(rd_E), .i_flush_M(flush_M),
        .o_stall_M(stall_M), .o_PCSrc_M(PCSrc_M), .o_PCBranch_M(PCBranch_M),
        .o_dm_req(dm_req), .o_dm_we(dm_we), .o_dm_addr(dm_addr), .o_dm_wdata(dm_wdata),
        .i_dm_ack(dm_ack), .i_dm_rdata(dm_rdata),
        .o_valid_W(valid_W), .o_regWrite_W(regWrite_W), .o_rd_W(rd_W),
        .o_result_W(result_W), .o_misalign_W(misalign_W)
    );

    // Memory responder: acks once dm_req has been seen for resp_delay+1 cycles.
    int   resp_delay = 0;
    int   req_cnt    = 0;
    logic auto_ack   = 1'b0;
    logic manual_ack = 1'b0;
    logic resp_en    = 1'b1;
    assign dm_ack = resp_en ? auto_ack : manual_ack;

    always @(negedge clk) begin
        if (dm_req === 1'b1) begin
            req_cnt  = req_cnt + 1;
            auto_ack = (req_cnt > resp_delay);
        end else begin
            req_cnt  = 0;
            auto_ack = 1'b0;
        end
    end

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [63:0] res;
        logic        chk_res;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0, n_fail = 0;
    int   mon_tests = 0, mon_fail = 0;

    // Monitor: every retired op on W must match the oldest expected entry.
    always @(negedge clk) begin
        if (valid_W === 1'b1) begin
            exp_t e;
            mon_tests = mon_tests + 1;
            if (sb.size() == 0) begin
                mon_fail = mon_fail + 1;
                $display("FAIL W_unexpected: valid_W=1 rd_W=%0d result_W=0x%0h, required no retirement",
                         rd_W, result_W);
            end else begin
                e = sb.pop_front();
                if (rd_W !== e.rd || regWrite_W !== e.rw || misalign_W !== e.mis ||
                    (e.chk_res && result_W !== e.res)) begin
                    mon_fail = mon_fail + 1;
                    $display("FAIL W_entry: got rd=%0d rw=%0b res=0x%0h mis=%0b, required rd=%0d rw=%0b res=0x%0h mis=%0b",
                             rd_W, regWrite_W, result_W, misalign_W, e.rd, e.rw, e.res, e.mis);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expect_w(input logic [4:0] rd, input logic rw, input logic [63:0] res,
                            input logic chk_res, input logic mis);
        exp_t e;
        e.rd = rd; e.rw = rw; e.res = res; e.chk_res = chk_res; e.mis = mis;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        valid_E = 0; memRead_E = 0; memWrite_E = 0; branch_E = 0; regWrite_E = 0;
        memtoReg_E = 0; aluResult_E = '0; writeData_E = '0; PCBranch_E = '0;
        zero_E = 0; rd_E = '0; flush_M = 0;
    endtask

    task automatic issue(input logic mr, input logic mw, input logic br, input logic rw,
                         input logic m2r, input logic z, input logic fl,
                         input logic [63:0] alu, input logic [63:0] wd,
                         input logic [63:0] pcb, input logic [4:0] rd);
        valid_E = 1; memRead_E = mr; memWrite_E = mw; branch_E = br; regWrite_E = rw;
        memtoReg_E = m2r; zero_E = z; flush_M = fl; aluResult_E = alu;
        writeData_E = wd; PCBranch_E = pcb; rd_E = rd;
    endtask

    // Follows a memory op from its capture edge through REQ; returns at the DONE negedge.
    task automatic run_mem(input string nm, input logic [63:0] addr, input logic we,
                           input logic [63:0] wdata, input int exp_cycles);
        int n = 0;
        logic bad = 1'b0;
        @(negedge clk);
        clear_inputs();
        while (dm_req === 1'b1 && n < 20) begin
            if (dm_addr !== addr || dm_we !== we || stall_M !== 1'b1 ||
                (we && dm_wdata !== wdata) || (n > 0 && valid_W !== 1'b0))
                bad = 1'b1;
            n = n + 1;
            @(negedge clk);
        end
        chk({nm, "_req_cycles"}, 64'(n), 64'(exp_cycles));
        chk({nm, "_req_signals_stable"}, {63'd0, bad}, 64'd0);
        chk({nm, "_done_stall"}, {63'd0, stall_M}, 64'd0);
        chk({nm, "_done_we"}, {63'd0, dm_we}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1'b0;
        dm_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {63'd0, stall_M}, 64'd0);
        chk("rst_dm_req", {63'd0, dm_req}, 64'd0);
        chk("rst_pcsrc", {63'd0, PCSrc_M}, 64'd0);
        chk("rst_valid_W", {63'd0, valid_W}, 64'd0);
        chk("rst_misalign", {63'd0, misalign_W}, 64'd0);
        chk("rst_result_W", result_W, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // ADD: single cycle in M
        issue(0, 0, 0, 1, 0, 0, 0, 64'h10, 64'h0, 64'h0, 5'd3);
        expect_w(5'd3, 1'b1, 64'h10, 1'b1, 1'b0);
        @(negedge clk);
        clear_inputs();
        chk("add_stall_m", {63'd0, stall_M}, 64'd0);
        @(negedge clk);
        chk("add_stall_w", {63'd0, stall_M}, 64'd0);

        // LDUR 0x40, ack on third REQ cycle
        resp_delay = 2;
        dm_rdata = 64'hDEADBEEF;
        issue(1, 0, 0, 1, 1, 0, 0, 64'h40, 64'h0, 64'h0, 5'd5);
        expect_w(5'd5, 1'b1, 64'hDEADBEEF, 1'b1, 1'b0);
        run_mem("ldur40", 64'h40, 1'b0, 64'h0, 3);
        @(negedge clk);

        // STUR 0x55 -> 0x80 with immediate ack, then back-to-back LDUR
        resp_delay = 0;
        issue(0, 1, 0, 0, 0, 0, 0, 64'h80, 64'h55, 64'h0, 5'd0);
        expect_w(5'd0, 1'b0, 64'h80, 1'b1, 1'b0);
        run_mem("stur80", 64'h80, 1'b1, 64'h55, 1);
        dm_rdata = 64'h12345678;
        issue(1, 0, 0, 1, 1, 0, 0, 64'h88, 64'h0, 64'h0, 5'd7);
        expect_w(5'd7, 1'b1, 64'h12345678, 1'b1, 1'b0);
        run_mem("ldur88_b2b", 64'h88, 1'b0, 64'h0, 1);
        @(negedge clk);

        // Taken branch, then the same branch flushed at capture
        issue(0, 0, 1, 0, 0, 1, 0, 64'h0, 64'h0, 64'h200, 5'd0);
        expect_w(5'd0, 1'b0, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        clear_inputs();
        chk("br_pcsrc", {63'd0, PCSrc_M}, 64'd1);
        chk("br_target", PCBranch_M, 64'h200);
        @(negedge clk);
        chk("br_pcsrc_one_cycle", {63'd0, PCSrc_M}, 64'd0);
        issue(0, 0, 1, 0, 0, 1, 1, 64'h0, 64'h0, 64'h200, 5'd0);
        @(negedge clk);
        clear_inputs();
        chk("flush_pcsrc", {63'd0, PCSrc_M}, 64'd0);
        @(negedge clk);
        chk("flush_valid_W", {63'd0, valid_W}, 64'd0);

        // Reset during REQ, followed by a late ack
        resp_en = 1'b0;
        issue(1, 0, 0, 1, 1, 0, 0, 64'h100, 64'h0, 64'h0, 5'd9);
        @(negedge clk);
        clear_inputs();
        chk("rstreq_req1", {63'd0, dm_req}, 64'd1);
        @(negedge clk);
        chk("rstreq_req2", {63'd0, dm_req}, 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("rstreq_req_dropped", {63'd0, dm_req}, 64'd0);
        chk("rstreq_stall_dropped", {63'd0, stall_M}, 64'd0);
        reset = 1'b1;
        manual_ack = 1'b1;
        dm_rdata = 64'hBAD;
        @(negedge clk);
        manual_ack = 1'b0;
        chk("late_ack_valid_W", {63'd0, valid_W}, 64'd0);
        chk("late_ack_result_W", result_W, 64'd0);
        chk("late_ack_req", {63'd0, dm_req}, 64'd0);
        @(negedge clk);
        chk("late_ack_valid_W2", {63'd0, valid_W}, 64'd0);
        resp_en = 1'b1;

        // LDUR to 0x43
`ifdef MEM_ALIGN_CHECK_EN
        issue(1, 0, 0, 1, 1, 0, 0, 64'h43, 64'h0, 64'h0, 5'd4);
        expect_w(5'd4, 1'b0, 64'h0, 1'b0, 1'b1);
        @(negedge clk);
        clear_inputs();
        chk("mis_no_req", {63'd0, dm_req}, 64'd0);
        chk("mis_no_stall", {63'd0, stall_M}, 64'd0);
        @(negedge clk);
        chk("mis_flag", {63'd0, misalign_W}, 64'd1);
        chk("mis_regwrite", {63'd0, regWrite_W}, 64'd0);
        @(negedge clk);
        chk("mis_flag_clears", {63'd0, misalign_W}, 64'd0);
`else
        resp_delay = 0;
        dm_rdata = 64'hABCD;
        issue(1, 0, 0, 1, 1, 0, 0, 64'h43, 64'h0, 64'h0, 5'd4);
        expect_w(5'd4, 1'b1, 64'hABCD, 1'b1, 1'b0);
        run_mem("ldur43", 64'h43, 1'b0, 64'h0, 1);
        @(negedge clk);
        chk("ldur43_no_misalign", {63'd0, misalign_W}, 64'd0);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        n_tests = n_tests + mon_tests;
        n_fail  = n_fail + mon_fail;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
